// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, register map and saturating add for the pid family
package pid_pkg;

    localparam int D_WIDTH = 16;
    localparam int Q_BITS  = 8;

    localparam int REG_PERIOD = 0;
    localparam int REG_LIM_HI = 1;
    localparam int REG_LIM_LO = 2;
    localparam int REG_LEVEL  = 3;

    // Sum is formed one bit wider so it can never wrap before clamping; hi is applied last so it wins.
    function automatic logic signed [D_WIDTH-1:0] sat_add(
        input logic signed [D_WIDTH-1:0] a,
        input logic signed [D_WIDTH-1:0] b,
        input logic signed [D_WIDTH-1:0] lo,
        input logic signed [D_WIDTH-1:0] hi
    );
        logic signed [D_WIDTH:0] s;
        s = $signed({a[D_WIDTH-1], a}) + $signed({b[D_WIDTH-1], b});
        s = (s < lo) ? D_WIDTH'(lo) : s;
        s = (s > hi) ? D_WIDTH'(hi) : s;
        return s[D_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: period counter, per-period duty latch, compare and period_start pulse
module pwm_counter #(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH:0]   duty,
    output logic                 pwm_out,
    output logic                 period_start
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [CNT_WIDTH:0]   duty_active;
    logic [CNT_WIDTH:0]   duty_next;

    // >= lets a shrinking period write take effect on the very next edge.
    always_comb begin
        cnt_next  = (cnt >= period) ? '0 : cnt + 1'b1;
        duty_next = (cnt_next == '0) ? duty : duty_active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            duty_active  <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            duty_active  <= duty_next;
            pwm_out      <= {1'b0, cnt_next} < duty_next;
            period_start <= cnt_next == '0;
        end
    end

endmodule

// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: integrates pid deltas into a clamped drive level and renders it as PWM
module pid_pwm_driver
    import pid_pkg::*;
#(
    parameter int D_WIDTH   = pid_pkg::D_WIDTH,
    parameter int CNT_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_enable,
    input  logic [D_WIDTH-1:0] reg_addr,
    input  logic [D_WIDTH-1:0] reg_data,
    input  logic [D_WIDTH-1:0] in,
    input  logic               in_valid,
    output logic [D_WIDTH-1:0] level,
    output logic               pwm_out,
    output logic               period_start
);

    logic [CNT_WIDTH-1:0]    period;
    logic [D_WIDTH-1:0]      lim_hi;
    logic [D_WIDTH-1:0]      lim_lo;
    logic signed [D_WIDTH:0] lvl_x;
    logic signed [D_WIDTH:0] top_x;
    logic [CNT_WIDTH:0]      duty;

    wire wr_period = !write_enable && reg_addr == D_WIDTH'(REG_PERIOD);
    wire wr_lim_hi = !write_enable && reg_addr == D_WIDTH'(REG_LIM_HI);
    wire wr_lim_lo = !write_enable && reg_addr == D_WIDTH'(REG_LIM_LO);
    wire wr_level  = !write_enable && reg_addr == D_WIDTH'(REG_LEVEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            period <= '1;
            lim_hi <= {1'b0, {(D_WIDTH-1){1'b1}}};
            lim_lo <= {1'b1, {(D_WIDTH-1){1'b0}}};
            level  <= '0;
        end else begin
            if (wr_period) period <= reg_data[CNT_WIDTH-1:0];
            if (wr_lim_hi) lim_hi <= reg_data;
            if (wr_lim_lo) lim_lo <= reg_data;
            // A preset is loaded raw and swallows any beat arriving on the same edge.
            if (wr_level)
                level <= reg_data;
            else if (in_valid)
                level <= sat_add(level, in, lim_lo, lim_hi);
        end
    end

    // Negative levels give 0% and anything beyond period+1 pins at 100%.
    always_comb begin
        lvl_x = $signed({level[D_WIDTH-1], level});
        top_x = $signed({{(D_WIDTH+1-CNT_WIDTH){1'b0}}, period}) + (D_WIDTH+1)'(1);
        duty  = (lvl_x < 0) ? '0 : (lvl_x > top_x) ? top_x[CNT_WIDTH:0] : lvl_x[CNT_WIDTH:0];
    end

    pwm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pwm (
        .clk          (clk),
        .rst          (rst),
        .period       (period),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

endmodule

// File: tb/tb_pid_pwm_driver.sv
// tb_pid_pwm_driver: directed and randomized checks against an integer reference model
module tb_pid_pwm_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_enable = 1'b1;
    logic [15:0] reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic [15:0] in = '0;
    logic        in_valid = 1'b0;
    logic [15:0] level;
    logic        pwm_out;
    logic        period_start;

    int n_checks = 0;
    int n_fail = 0;

    int m_level, m_period, m_hi, m_lo, m_cnt, m_duty;
    bit m_pwm, m_ps;

    pid_pwm_driver dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .in           (in),
        .in_valid     (in_valid),
        .level        (level),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Advance one edge; the model follows the behavioural rules with plain integers.
    task automatic tick();
        int d, nc;
        @(posedge clk);
        if (rst) begin
            m_level = 0; m_period = 4095; m_hi = 32767; m_lo = -32768;
            m_cnt = 0; m_duty = 0; m_pwm = 0; m_ps = 0;
        end else begin
            d = (m_level < 0) ? 0 : (m_level > m_period + 1) ? m_period + 1 : m_level;
            nc = (m_cnt >= m_period) ? 0 : m_cnt + 1;
            if (nc == 0) m_duty = d;
            m_cnt = nc;
            m_pwm = nc < m_duty;
            m_ps = nc == 0;
            if (!write_enable && reg_addr == 16'd3) m_level = sx(reg_data);
            else if (in_valid) begin
                m_level = m_level + sx(in);
                if (m_level < m_lo) m_level = m_lo;
                if (m_level > m_hi) m_level = m_hi;
            end
            if (!write_enable && reg_addr == 16'd0) m_period = int'(reg_data[11:0]);
            if (!write_enable && reg_addr == 16'd1) m_hi = sx(reg_data);
            if (!write_enable && reg_addr == 16'd2) m_lo = sx(reg_data);
        end
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        write_enable = 1'b0; reg_addr = a; reg_data = d;
        tick();
        write_enable = 1'b1;
    endtask

    task automatic sync_period();
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 5000 && !m_ps; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (level !== 16'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm got=%b want=0", pwm_out); end
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL reset_ps got=%b want=0", period_start); end
    endtask

    task automatic test_duty_basic();
        int highs, starts;
        wr(16'd0, 16'd9);
        wr(16'd3, 16'd5);
        sync_period();
        highs = 0; starts = 0;
        for (int i = 0; i < 20; i++) begin
            highs += int'(pwm_out);
            starts += int'(period_start);
            n_checks++; if (pwm_out !== m_pwm) begin n_fail++; $display("FAIL duty5_pwm cyc=%0d got=%b want=%b", i, pwm_out, m_pwm); end
            tick();
        end
        n_checks++; if (highs != 10) begin n_fail++; $display("FAIL duty5_high_count got=%0d want=10", highs); end
        n_checks++; if (starts != 2) begin n_fail++; $display("FAIL duty5_start_count got=%0d want=2", starts); end
        n_checks++; if (level !== 16'd5) begin n_fail++; $display("FAIL duty5_level got=%0d want=5", level); end
    endtask

    task automatic test_accumulate();
        wr(16'd3, 16'd0);
        in_valid = 1'b1; in = 16'd3;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (level !== 16'(3 * k)) begin n_fail++; $display("FAIL acc_step%0d got=%0d want=%0d", k, level, 3 * k); end
        end
        in_valid = 1'b0;
        sync_period();
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (pwm_out !== 1'b1) begin n_fail++; $display("FAIL acc_full_duty cyc=%0d got=%b want=1", i, pwm_out); end
            tick();
        end
    endtask

    task automatic test_saturation();
        wr(16'd1, 16'd100);
        wr(16'd3, 16'd90);
        in_valid = 1'b1; in = 16'd20;
        tick();
        n_checks++; if (level !== 16'd100) begin n_fail++; $display("FAIL sat_hi got=%0d want=100", $signed(level)); end
        in_valid = 1'b0;
        wr(16'd1, 16'h7FFF);
        wr(16'd3, 16'(-32000));
        in_valid = 1'b1; in = 16'h8000;
        tick();
        n_checks++; if (level !== 16'h8000) begin n_fail++; $display("FAIL sat_lo got=%0d want=-32768", $signed(level)); end
        tick();
        n_checks++; if (level !== 16'h8000) begin n_fail++; $display("FAIL sat_lo_hold got=%0d want=-32768", $signed(level)); end
        in_valid = 1'b0;
    endtask

    task automatic test_negative();
        wr(16'd3, 16'(-50));
        sync_period();
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL neg_level_pwm cyc=%0d got=%b want=0", i, pwm_out); end
            tick();
        end
    endtask

    task automatic test_timing();
        bit exp;
        wr(16'd3, 16'd5);
        sync_period();
        for (int i = 0; i < 20; i++) begin
            exp = (i < 5) || (i == 10) || (i == 11);
            n_checks++; if (pwm_out !== exp) begin n_fail++; $display("FAIL midperiod_change cyc=%0d got=%b want=%b", i, pwm_out, exp); end
            if (i == 2) begin write_enable = 1'b0; reg_addr = 16'd3; reg_data = 16'd2; end
            tick();
            write_enable = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        write_enable = 1'b0; reg_addr = 16'd3; reg_data = 16'd77;
        in_valid = 1'b1; in = 16'd5;
        tick();
        write_enable = 1'b1;
        n_checks++; if (level !== 16'd77) begin n_fail++; $display("FAIL preset_wins got=%0d want=77", level); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 16'd82) begin n_fail++; $display("FAIL acc_after_preset got=%0d want=82", level); end
        wr(16'h0103, 16'd1);
        n_checks++; if (level !== 16'd82) begin n_fail++; $display("FAIL ignored_addr got=%0d want=82", level); end
    endtask

    task automatic test_period_shrink();
        wr(16'd0, 16'd4095);
        for (int i = 0; i < 5000 && m_cnt != 800; i++) tick();
        wr(16'd0, 16'd99);
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL shrink_ps_before got=%b want=0", period_start); end
        tick();
        n_checks++; if (period_start !== 1'b1) begin n_fail++; $display("FAIL shrink_ps_wrap got=%b want=1", period_start); end
        for (int i = 0; i < 210; i++) begin
            tick();
            n_checks++; if (period_start !== m_ps) begin n_fail++; $display("FAIL shrink_ps cyc=%0d got=%b want=%b", i, period_start, m_ps); end
        end
    endtask

    task automatic test_random();
        logic [15:0] addrs [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'h0103};
        for (int i = 0; i < 600; i++) begin
            write_enable = ($urandom_range(0, 5) != 0);
            reg_addr = addrs[$urandom_range(0, 5)];
            case ($urandom_range(0, 2))
                0: reg_data = 16'($urandom_range(0, 20));
                1: reg_data = 16'(int'($urandom_range(0, 40)) - 10);
                default: reg_data = 16'($urandom);
            endcase
            in_valid = $urandom_range(0, 1) != 0;
            in = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 10)) - 5);
            tick();
            n_checks++; if (level !== 16'(m_level)) begin n_fail++; if (n_fail < 30) $display("FAIL rand_level cyc=%0d got=%0d want=%0d", i, $signed(level), m_level); end
            n_checks++; if (pwm_out !== m_pwm) begin n_fail++; if (n_fail < 30) $display("FAIL rand_pwm cyc=%0d got=%b want=%b", i, pwm_out, m_pwm); end
            n_checks++; if (period_start !== m_ps) begin n_fail++; if (n_fail < 30) $display("FAIL rand_ps cyc=%0d got=%b want=%b", i, period_start, m_ps); end
        end
        write_enable = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        wr(16'd0, 16'd6);
        wr(16'd1, 16'd10);
        wr(16'd2, 16'd3);
        wr(16'd3, 16'd4);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (level !== 16'd0) begin n_fail++; $display("FAIL midrst_level got=%0d want=0", level); end
        n_checks++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL midrst_pwm got=%b want=0", pwm_out); end
        n_checks++; if (period_start !== 1'b0) begin n_fail++; $display("FAIL midrst_ps got=%b want=0", period_start); end
        wr(16'd3, 16'h7FFE);
        in_valid = 1'b1; in = 16'd100;
        tick();
        n_checks++; if (level !== 16'h7FFF) begin n_fail++; $display("FAIL midrst_lim_hi got=%0d want=32767", $signed(level)); end
        in_valid = 1'b0;
        wr(16'd3, 16'h8001);
        in_valid = 1'b1; in = 16'(-100);
        tick();
        n_checks++; if (level !== 16'h8000) begin n_fail++; $display("FAIL midrst_lim_lo got=%0d want=-32768", $signed(level)); end
        in_valid = 1'b0;
        wr(16'd3, 16'd2000);
        for (int i = 0; i < 4200; i++) begin
            tick();
            n_checks++; if (period_start !== m_ps || pwm_out !== m_pwm) begin n_fail++; if (n_fail < 30) $display("FAIL midrst_period cyc=%0d got ps=%b pwm=%b want ps=%b pwm=%b", i, period_start, pwm_out, m_ps, m_pwm); end
        end
    endtask

    initial begin
        test_reset();
        test_duty_basic();
        test_accumulate();
        test_saturation();
        test_negative();
        test_timing();
        test_back_to_back();
        test_period_shrink();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
